// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: op codes, FSM states and the
// default word and RAM sizes.
package load_store_unit_pkg;

  localparam int WORDSIZE    = 32;
  localparam int ROM_COL_MAX = 1024;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic for the big-endian load/store unit: request
// checking, load lane extraction with extension, and store lane merging.
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN      = WORDSIZE,
  parameter int MEM_BYTES = ROM_COL_MAX
) (
  input  logic [2:0]      op,
  input  logic            we,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] rd_word,
  input  logic [XLEN-1:0] mod_word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged,
  output logic            err
);

  logic [4:0]      byte_shift;
  logic [4:0]      half_shift;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] ins;
  logic [XLEN:0]   end_addr;
  logic            illegal;
  logic            misaligned;
  logic            out_of_range;

  // Big-endian: offset 0 is the most significant lane, so shift by (3-off)*8.
  assign byte_shift = {~addr[1:0], 3'b000};
  assign half_shift = {~addr[1], 4'b0000};
  assign lane_b     = 8'(rd_word >> byte_shift);
  assign lane_h     = 16'(rd_word >> half_shift);

  always_comb begin
    load_data = '0;
    case (op)
      OP_B:    load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
      OP_BU:   load_data = {{(XLEN-8){1'b0}}, lane_b};
      OP_H:    load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
      OP_HU:   load_data = {{(XLEN-16){1'b0}}, lane_h};
      OP_W:    load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    mask = '1;
    ins  = wdata;
    if (op[1:0] == 2'b00) begin
      mask = XLEN'(8'hFF) << byte_shift;
      ins  = XLEN'(wdata[7:0]) << byte_shift;
    end else if (op[1:0] == 2'b01) begin
      mask = XLEN'(16'hFFFF) << half_shift;
      ins  = XLEN'(wdata[15:0]) << half_shift;
    end
    merged = (mod_word & ~mask) | ins;
  end

  // One extra bit on the end address keeps the bounds compare free of wrap.
  assign end_addr     = {1'b0, addr[XLEN-1:2], 2'b00} + (XLEN+1)'(4);
  assign out_of_range = end_addr > (XLEN+1)'(MEM_BYTES);
  assign illegal      = (op[1:0] == 2'b11) || (op == 3'b110) || (op[2] && we);
  assign misaligned   = ((op[1:0] == 2'b01) && addr[0]) ||
                        ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign err          = illegal || misaligned || out_of_range;

endmodule

// File: rtl/load_store_unit.sv
// Load/store master for the single-port data RAM; sub-word stores are done
// as read-modify-write of the aligned word.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = ROM_COL_MAX,
  parameter int XLEN      = WORDSIZE
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_read_data
);

  lsu_state_t      state;
  lsu_state_t      next_state;
  logic [2:0]      op_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic [2:0]      op_sel;
  logic            we_sel;
  logic [XLEN-1:0] addr_sel;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged;
  logic            chk_err;

  // In IDLE the checker looks at the incoming request, afterwards at the captured one.
  assign op_sel   = (state == IDLE) ? req_op   : op_q;
  assign we_sel   = (state == IDLE) ? req_we   : we_q;
  assign addr_sel = (state == IDLE) ? req_addr : addr_q;

  lsu_align #(.XLEN(XLEN), .MEM_BYTES(MEM_BYTES)) u_align (
    .op        (op_sel),
    .we        (we_sel),
    .addr      (addr_sel),
    .rd_word   (mem_read_data),
    .mod_word  (word_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged),
    .err       (chk_err)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (req_valid) begin
          op_q    <= req_op;
          we_q    <= req_we;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          err_q   <= chk_err;
          rdata_q <= '0;
        end
        READ: begin
          word_q <= mem_read_data;
          if (!we_q) rdata_q <= load_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) begin
        if (chk_err)                              next_state = RESP;
        else if (!req_we || req_op[1:0] != 2'b10) next_state = READ;
        else                                      next_state = WRITE;
      end
      READ:    next_state = we_q ? WRITE : RESP;
      WRITE:   next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state == IDLE);
    resp_valid     = (state == RESP);
    resp_rdata     = '0;
    resp_err       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state)
      READ: begin
        mem_read = 1'b1;
        mem_addr = {addr_q[XLEN-1:2], 2'b00};
      end
      WRITE: begin
        mem_write      = 1'b1;
        mem_addr       = {addr_q[XLEN-1:2], 2'b00};
        mem_write_data = merged;
      end
      RESP: begin
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected responses
// and RAM writes, a negedge monitor pops and compares them.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int MB = 1024;

  logic        CLK;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  load_store_unit #(.MEM_BYTES(MB), .XLEN(32)) dut (
    .CLK            (CLK),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: combinational read, write on the clock edge.
  logic [31:0] ram [0:255];
  assign mem_read_data = ram[mem_addr[9:2]];
  always @(posedge CLK) if (mem_write) ram[mem_addr[9:2]] <= mem_write_data;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
    int          hold;
    string       name;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          at;
    string       name;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    total = 0;
  int    bad = 0;
  int    reads_seen = 0;
  int    reads_exp = 0;

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h want=0x%08h", name, got, exp);
    end
  endtask

  task automatic failNow(string name, logic [31:0] got);
    total++;
    bad++;
    $display("[TB] FAIL %s: got=0x%08h want=none", name, got);
  endtask

  task automatic applyStimulus(string name, logic [2:0] op, logic we,
                               logic [31:0] addr, logic [31:0] wdata,
                               logic [31:0] exp_rdata, logic exp_err, int lat,
                               int hold, logic [31:0] exp_waddr,
                               logic [31:0] exp_wdata, int wr_lat, int n_reads);
    int  waited;
    int  a;
    logic ready_now;
    waited = 0;
    @(negedge CLK);
    req_op    = op;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    forever begin
      ready_now = req_ready;
      @(posedge CLK);
      if (ready_now) break;
      waited++;
      if (waited > 50) break;
      @(negedge CLK);
    end
    #1;
    req_valid = 1'b0;
    if (waited > 50) begin
      failNow({name, "_accept_timeout"}, 32'(waited));
    end else begin
      a = cyc;
      resp_q.push_back('{exp_rdata, exp_err, a + lat - 1, hold, name});
      if (wr_lat > 0) wr_q.push_back('{exp_waddr, exp_wdata, a + wr_lat - 1, name});
      reads_exp += n_reads;
    end
  endtask

  task automatic doLoad(string name, logic [2:0] op, logic [31:0] addr, logic [31:0] exp, int hold);
    applyStimulus(name, op, 1'b0, addr, 32'h0, exp, 1'b0, 2, hold, 32'h0, 32'h0, 0, 1);
  endtask

  task automatic doErr(string name, logic [2:0] op, logic we, logic [31:0] addr);
    applyStimulus(name, op, we, addr, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((resp_q.size() != 0 || resp_valid) && t < 100) begin
      @(posedge CLK);
      t++;
    end
    if (t >= 100) failNow("drain_timeout", 32'(t));
    @(negedge CLK);
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    checkOutput({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_write_data, 32'd0);
  endtask

  // Monitor: compares RAM writes and responses against the queues.
  initial begin
    resp_t cur;
    wr_t   w;
    int    hold_left;
    bit    in_resp;
    in_resp   = 1'b0;
    hold_left = 0;
    resp_ready = 1'b1;
    forever begin
      @(negedge CLK);
      if (reset) begin
        in_resp    = 1'b0;
        resp_ready = 1'b1;
      end else begin
        if (mem_read) reads_seen++;
        if (mem_read && mem_write) failNow("rd_wr_both", mem_addr);
        if (!mem_read && !mem_write && mem_addr != 32'h0)
          checkOutput("idle_mem_addr", mem_addr, 32'h0);
        if (mem_write) begin
          if (wr_q.size() == 0) begin
            failNow("unexpected_write", mem_addr);
          end else begin
            w = wr_q.pop_front();
            checkOutput({w.name, "_waddr"}, mem_addr, w.addr);
            checkOutput({w.name, "_wdata"}, mem_write_data, w.data);
            checkOutput({w.name, "_wcycle"}, 32'(cyc), 32'(w.at));
          end
        end
        if (!resp_valid) begin
          in_resp = 1'b0;
        end else if (!in_resp) begin
          in_resp = 1'b1;
          if (resp_q.size() == 0) begin
            failNow("unexpected_resp", resp_rdata);
            resp_ready = 1'b1;
          end else begin
            cur = resp_q.pop_front();
            checkOutput({cur.name, "_rdata"}, resp_rdata, cur.rdata);
            checkOutput({cur.name, "_err"}, 32'(resp_err), 32'(cur.err));
            checkOutput({cur.name, "_rcycle"}, 32'(cyc), 32'(cur.at));
            hold_left  = cur.hold;
            resp_ready = (hold_left == 0);
          end
        end else begin
          checkOutput({cur.name, "_hold_rdata"}, resp_rdata, cur.rdata);
          checkOutput({cur.name, "_hold_err"}, 32'(resp_err), 32'(cur.err));
          checkOutput({cur.name, "_hold_req_ready"}, 32'(req_ready), 32'd0);
          if (hold_left > 0) hold_left--;
          if (hold_left == 0) resp_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got=0x%08h want=none", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    checkResetOutputs("reset");
    @(negedge CLK);
    reset = 1'b0;

    applyStimulus("sw_10", OP_W, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0,
                  32'h10, 32'hDEAD_BEEF, 1, 0);
    doLoad("lb_11",  OP_B,  32'h11, 32'hFFFF_FFAD, 0);
    doLoad("lbu_11", OP_BU, 32'h11, 32'h0000_00AD, 0);
    doLoad("lh_12",  OP_H,  32'h12, 32'hFFFF_BEEF, 0);
    doLoad("lhu_10", OP_HU, 32'h10, 32'h0000_DEAD, 0);
    applyStimulus("sb_12", OP_B, 1'b1, 32'h12, 32'h0000_0055, 32'h0, 1'b0, 3, 0,
                  32'h10, 32'hDEAD_55EF, 2, 1);
    doLoad("lw_10",  OP_W,  32'h10, 32'hDEAD_55EF, 0);
    doLoad("lb_13",  OP_B,  32'h13, 32'hFFFF_FFEF, 0);

    doErr("lh_13_mis",   OP_H, 1'b0, 32'h13);
    doErr("sw_12_mis",   OP_W, 1'b1, 32'h12);
    doErr("lw_3fe_mis",  OP_W, 1'b0, 32'(MB - 2));
    doErr("lw_400_oob",  OP_W, 1'b0, 32'(MB));
    doErr("op_011",      3'b011, 1'b0, 32'h10);
    doErr("sbu_illegal", OP_BU, 1'b1, 32'h10);

    applyStimulus("sw_3fc", OP_W, 1'b1, 32'(MB - 4), 32'hCAFE_F00D, 32'h0, 1'b0, 2, 0,
                  32'(MB - 4), 32'hCAFE_F00D, 1, 0);
    doLoad("lw_3fc",  OP_W,  32'(MB - 4), 32'hCAFE_F00D, 0);
    doLoad("lhu_3fe", OP_HU, 32'(MB - 2), 32'h0000_F00D, 0);

    doLoad("lw_hold", OP_W, 32'h10, 32'hDEAD_55EF, 5);
    doLoad("lb_10",   OP_B, 32'h10, 32'hFFFF_FFDE, 0);

    drain();
    checkOutput("rst_pre_ready", 32'(req_ready), 32'd1);
    req_op    = OP_B;
    req_we    = 1'b1;
    req_addr  = 32'h12;
    req_wdata = 32'h0000_0099;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    checkOutput("rst_in_read", 32'(mem_read), 32'd1);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    checkResetOutputs("midreset");
    @(negedge CLK);
    reset = 1'b0;

    doLoad("lw_after_rst", OP_W, 32'h10, 32'hDEAD_55EF, 0);
    applyStimulus("sh_10", OP_H, 1'b1, 32'h10, 32'hABCD_1234, 32'h0, 1'b0, 3, 0,
                  32'h10, 32'h1234_55EF, 2, 1);
    doLoad("lhu_12", OP_HU, 32'h12, 32'h0000_55EF, 0);
    doLoad("lh_10",  OP_H,  32'h10, 32'h0000_1234, 0);

    drain();
    repeat (3) @(negedge CLK);
    checkOutput("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    checkOutput("write_queue_empty", 32'(wr_q.size()), 32'd0);
    checkOutput("mem_read_cycles", 32'(reads_seen), 32'(reads_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side master for the single-port data RAM (ports addr / write_data / memread / memwrite / read_data).
- Sits between the EX stage and the RAM. Accepts one load or store request per handshake.
- Loads: extracts the byte, halfword or word and sign- or zero-extends it.
- Sub-word stores: performed as read-modify-write (RMW) on the aligned word.
- Checks alignment and address bounds and returns a response with an error flag.

Parameters:
- MEM_BYTES, default `ROM_COL_MAX: RAM size in bytes. Any access touching byte >= MEM_BYTES is an error.
- XLEN, default `WORDSIZE (32): data and address width.

Ports:
- CLK  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  access type: LB=000 LH=001 LW=010 LBU=100 LHU=101 SB=000, SH=001, SW=010 with req_we=1
- req_we  in  1  1=store, 0=load
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data; right-justified for SB/SH
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range access
- mem_addr  out  XLEN  to RAM addr; always word-aligned
- mem_write_data  out  XLEN  to RAM write_data
- mem_read  out  1  to RAM memread
- mem_write  out  1  to RAM memwrite
- mem_read_data  in  XLEN  from RAM read_data

Behaviour:
- Clock and reset: single clock CLK; reset is synchronous and active-high.
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_read=0; mem_write=0; mem_addr=0; mem_write_data=0.
- Reset mid-operation: abandons the request with no further mem_write. A write already in its WRITE cycle at the reset edge may or may not commit.
- Byte order is big-endian:
  - byte offset 0 = word bits [31:24]; offset 3 = bits [7:0].
  - halfword offset 0 = [31:16]; offset 2 = [15:0].
- Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
- Bounds: error if (addr & ~3) + 4 > MEM_BYTES.
- Illegal op codes (011, 110, 111, or loads with 1xx while req_we=1) are errors.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1. On req_valid, capture op, we, addr and wdata.
  - Error: go to RESP with err=1. No RAM access at all.
  - Load, SB or SH: go to READ.
  - SW: go to WRITE.
- READ (1 cycle):
  - mem_read=1; mem_addr = addr with bits [1:0] cleared.
  - Register mem_read_data at the closing edge.
  - Load: go to RESP with extracted and extended data.
  - SB/SH: go to WRITE.
- WRITE (1 cycle):
  - mem_write=1; mem_addr = aligned address.
  - SW: mem_write_data = wdata.
  - SB/SH: mem_write_data = captured word with the target lane replaced by wdata[7:0] or wdata[15:0]; all other bytes unchanged.
  - Then go to RESP.
- RESP:
  - resp_valid=1, held stable until resp_ready=1; then go to IDLE.
  - req_ready=0 in every state except IDLE.
- Latency, counting the accept edge as T:
  - LW/LB/etc.: resp_valid from T+2.
  - SW: resp_valid from T+2.
  - SB/SH: resp_valid from T+3.
  - Error: resp_valid from T+1.
- Outside READ/WRITE: mem_read=0, mem_write=0, mem_addr=0. mem_read and mem_write are never both 1.
- Back-to-back requests: the next accept cannot occur earlier than the cycle after the resp handshake. Throughput is 1 request per 3 cycles minimum (LW with resp_ready tied high).

Decomposition:
- defs.v: op-code constants (OP_B, OP_H, OP_W, OP_BU, OP_HU), FSM state encodings, reuse of `WORDSIZE and `ROM_COL_MAX.
- One combinational sub-module, lsu_align. It provides:
  - lane extract plus sign/zero extend for loads;
  - lane merge for stores;
  - the alignment/illegal check.
- The FSM stays in load_store_unit.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF: exactly one mem_write cycle at T+1 with mem_addr=0x10, data 0xDEADBEEF; resp_err=0 at T+2.
- After that, LB 0x11: resp_rdata=0xFFFFFFAD. LBU 0x11: 0x000000AD. LH 0x12: 0xFFFFBEEF. LHU 0x10: 0x0000DEAD.
- SB addr=0x12 wdata=0x00000055: READ at T+1, WRITE at T+2 with mem_addr=0x10 and data 0xDEAD55EF, resp at T+3; a following LW 0x10 returns 0xDEAD55EF.
- LH 0x13 and SW 0x12: resp_err=1 at T+1, resp_rdata=0, mem_read and mem_write never asserted. LW at MEM_BYTES-2 gives the same result.
- Hold resp_ready=0 for 5 cycles on a response: resp_valid and resp_rdata stay stable, req_ready=0, and a req_valid presented meanwhile is not accepted.
- Assert reset during the READ of an SB: no mem_write ever occurs, all outputs return to reset values next cycle, and the word at 0x10 is unchanged.
